// File: rtl/pll_mon_pkg.sv
// Shared types and helpers for the PLL lock monitor.
package pll_mon_pkg;

    // Supervisor FSM encoding; values are visible on the debug state port.
    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StSettle   = 2'd1,
        StRun      = 2'd2
    } mon_state_e;

    // Counter value at which a missing ref_tick rise is declared a frequency fault.
    function automatic int unsigned timeout_cycles(input int unsigned ref_period,
                                                   input int unsigned freq_tol);
        return ref_period + freq_tol + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for a single asynchronous level, async active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Plain two-flop chain; the first stage may go metastable and is never used directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// Holds the system in reset until the PLL is locked and on frequency, measured against ref_tick.
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned REF_PERIOD    = 120,
    parameter int unsigned FREQ_TOL      = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pll_lock,
    input  logic             ref_tick,
    output logic             sys_reset,
    output logic             freq_ok,
    output logic [CNT_W-1:0] period_meas,
    output logic [7:0]       lock_lost_count,
    output logic [1:0]       state
);

    localparam int unsigned TIMEOUT  = timeout_cycles(REF_PERIOD, FREQ_TOL);
    localparam int unsigned SETTLE_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned LO_BOUND = (REF_PERIOD > FREQ_TOL) ? REF_PERIOD - FREQ_TOL : 0;
    localparam int unsigned HI_BOUND = REF_PERIOD + FREQ_TOL;

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    CNT_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]    CNT_LO      = CNT_W'(LO_BOUND);
    localparam logic [CNT_W-1:0]    CNT_HI      = CNT_W'(HI_BOUND);

    logic lock_s;
    logic tick_s;

    sync_2ff u_sync_lock (
        .clk   (clk),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    sync_2ff u_sync_tick (
        .clk   (clk),
        .reset (reset),
        .d     (ref_tick),
        .q     (tick_s)
    );

    // ---------------------------------------------------------------- frequency measurement
    logic             tick_q, tick_d;
    logic             tick_rise;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] meas_q, meas_d;
    logic             freq_ok_q, freq_ok_d;
    logic             first_q, first_d;
    logic             valid_q, valid_d;
    logic             in_tol;

    // Measurement registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q    <= 1'b0;
            cnt_q     <= '0;
            meas_q    <= '0;
            freq_ok_q <= 1'b0;
            first_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            cnt_q     <= cnt_d;
            meas_q    <= meas_d;
            freq_ok_q <= freq_ok_d;
            first_q   <= first_d;
            valid_q   <= valid_d;
        end
    end

    // Period counting, latching on each rise and timeout detection between rises.
    always_comb begin
        tick_d    = tick_s;
        tick_rise = tick_s & ~tick_q;
        in_tol    = (cnt_q >= CNT_LO) && (cnt_q <= CNT_HI);
        cnt_d     = cnt_q;
        meas_d    = meas_q;
        freq_ok_d = freq_ok_q;
        first_d   = first_q;
        valid_d   = valid_q;
        if (tick_rise) begin
            cnt_d   = CNT_W'(1);
            meas_d  = cnt_q;
            first_d = 1'b1;
            // The first rise after reset only opens a window; its count is meaningless.
            if (first_q) begin
                valid_d = 1'b1;
            end
            freq_ok_d = valid_d && in_tol;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Clear as soon as the counter reaches the limit; saturation stays past it.
            if (cnt_d >= CNT_TIMEOUT) begin
                freq_ok_d = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- supervisor FSM
    mon_state_e          state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [7:0]          lost_q, lost_d;
    logic                sys_reset_q, sys_reset_d;

    // State register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StWaitLock;
            settle_q    <= '0;
            lost_q      <= '0;
            sys_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            lost_q      <= lost_d;
            sys_reset_q <= sys_reset_d;
        end
    end

    // Next-state logic; settle count saturates at its last value while waiting for freq_ok.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        unique case (state_q)
            StWaitLock: begin
                settle_d = '0;
                if (lock_s) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (!lock_s) begin
                    state_d  = StWaitLock;
                    settle_d = '0;
                end else begin
                    settle_d = (settle_q == SETTLE_LAST) ? settle_q
                                                         : settle_q + SETTLE_W'(1);
                    if ((settle_d == SETTLE_LAST) && freq_ok_q) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (!lock_s || !freq_ok_q) begin
                    state_d = StWaitLock;
                end
            end
            default: begin
                state_d  = StWaitLock;
                settle_d = '0;
            end
        endcase
    end

    // Output logic: reset follows the next state; one count per RUN exit, saturating.
    always_comb begin
        sys_reset_d = (state_d != StRun);
        lost_d      = lost_q;
        if ((state_q == StRun) && (state_d != StRun) && (lost_q != 8'hFF)) begin
            lost_d = lost_q + 8'd1;
        end
    end

    assign sys_reset       = sys_reset_q;
    assign freq_ok         = freq_ok_q;
    assign period_meas     = meas_q;
    assign lock_lost_count = lost_q;
    assign state           = state_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Randomized bench for pll_lock_monitor with a timestamp-based reference model.
module tb_pll_lock_monitor;

    localparam int REF          = 120;
    localparam int TOL          = 2;
    localparam int TIMEOUT_C    = REF + TOL + 1;
    localparam int SHORT_STABLE = 16;
    localparam int HIST         = 65536;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pll_lock = 1'b0;
    logic        ref_tick = 1'b0;
    logic        sr  [2];
    logic        fok [2];
    logic [15:0] pm  [2];
    logic [7:0]  llc [2];
    logic [1:0]  st  [2];

    int n_total = 0;
    int n_bad   = 0;

    always #4 clk = ~clk;

    pll_lock_monitor u_dut (
        .clk             (clk),
        .reset           (reset),
        .pll_lock        (pll_lock),
        .ref_tick        (ref_tick),
        .sys_reset       (sr[0]),
        .freq_ok         (fok[0]),
        .period_meas     (pm[0]),
        .lock_lost_count (llc[0]),
        .state           (st[0])
    );

    pll_lock_monitor #(.STABLE_CYCLES(SHORT_STABLE)) u_dut_short (
        .clk             (clk),
        .reset           (reset),
        .pll_lock        (pll_lock),
        .ref_tick        (ref_tick),
        .sys_reset       (sr[1]),
        .freq_ok         (fok[1]),
        .period_meas     (pm[1]),
        .lock_lost_count (llc[1]),
        .state           (st[1])
    );

    // Stimulus state; histories are indexed by clock edges since the last reset release.
    bit lock_x   = 1'b1;
    bit tick_en  = 1'b1;
    int tick_per = REF;
    int tick_ph  = 0;
    bit lock_hist [HIST];
    bit tick_hist [HIST];
    int p = 0;

    // Reference model: event timestamps plus a coarse supervisor state per instance.
    int m_last, m_rises, m_meas;
    bit m_fok;
    int m_st [2];
    int m_ss [2];
    int m_lost [2];
    bit m_sr [2];
    int stable_of [2];
    int rel_cycle0 = -1;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit lock_s_at(input int q);
        return (q >= 2) ? lock_hist[q-2] : 1'b0;
    endfunction

    function automatic bit tick_s_at(input int q);
        return (q >= 2) ? tick_hist[q-2] : 1'b0;
    endfunction

    function automatic bit tick_rise_at(input int q);
        return tick_s_at(q) && !tick_s_at(q - 1);
    endfunction

    task automatic model_reset();
        p       = 0;
        m_last  = 0;
        m_rises = 0;
        m_meas  = 0;
        m_fok   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_st[i]   = 0;
            m_ss[i]   = 0;
            m_lost[i] = 0;
            m_sr[i]   = 1'b1;
        end
        lock_hist[0] = pll_lock;
        tick_hist[0] = ref_tick;
    endtask

    // Advance the model to the values expected just after edge p.
    task automatic model_update();
        int  q;
        int  meas;
        int  dev;
        bit  ls;
        bit  old_fok;
        q       = p - 1;
        ls      = lock_s_at(q);
        old_fok = m_fok;
        for (int i = 0; i < 2; i++) begin
            case (m_st[i])
                0: if (ls) begin
                    m_st[i] = 1;
                    m_ss[i] = p;
                end
                1: if (!ls) m_st[i] = 0;
                   else if ((p - m_ss[i] >= stable_of[i] - 1) && old_fok) m_st[i] = 2;
                default: if (!ls || !old_fok) begin
                    m_st[i] = 0;
                    if (m_lost[i] < 255) m_lost[i]++;
                end
            endcase
            m_sr[i] = (m_st[i] != 2);
        end
        if (tick_rise_at(q)) begin
            meas = q - m_last;
            if (meas > 65535) meas = 65535;
            dev   = (meas > REF) ? meas - REF : REF - meas;
            m_fok = (m_rises >= 1) && (dev <= TOL);
            m_meas = meas;
            m_rises++;
            m_last = q;
        end else if (p - m_last >= TIMEOUT_C) begin
            m_fok = 1'b0;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("sys_reset[%0d]@%0d", i, p), sr[i], m_sr[i]);
            check_eq($sformatf("freq_ok[%0d]@%0d", i, p), fok[i], m_fok);
            check_eq($sformatf("period_meas[%0d]@%0d", i, p), pm[i], m_meas);
            check_eq($sformatf("lost_count[%0d]@%0d", i, p), llc[i], m_lost[i]);
            check_eq($sformatf("state[%0d]@%0d", i, p), st[i], m_st[i]);
        end
    endtask

    task automatic drive();
        bit t;
        t = 1'b0;
        if (tick_en) begin
            t       = (tick_ph < tick_per / 2);
            tick_ph = (tick_ph + 1 >= tick_per) ? 0 : tick_ph + 1;
        end
        pll_lock     = lock_x;
        ref_tick     = t;
        lock_hist[p] = lock_x;
        tick_hist[p] = t;
    endtask

    task automatic step();
        @(posedge clk);
        p++;
        if (p >= HIST - 1) begin
            $display("FAIL history_overflow: got %0d expected below %0d", p, HIST - 1);
            $fatal(1, "history overflow");
        end
        model_update();
        #1;
        compare_all();
        if (rel_cycle0 < 0 && sr[0] == 1'b0) rel_cycle0 = p;
        drive();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("%s_sys_reset[%0d]", tag, i), sr[i], 1);
            check_eq($sformatf("%s_freq_ok[%0d]", tag, i), fok[i], 0);
            check_eq($sformatf("%s_period_meas[%0d]", tag, i), pm[i], 0);
            check_eq($sformatf("%s_lost_count[%0d]", tag, i), llc[i], 0);
            check_eq($sformatf("%s_state[%0d]", tag, i), st[i], 0);
        end
    endtask

    // Asynchronous reset pulse placed away from the clock edges.
    task automatic pulse_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values(tag);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int nrise;
        stable_of[0] = 1024;
        stable_of[1] = SHORT_STABLE;
        pll_lock = 1'b1;
        ref_tick = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Clean power-up with lock present from the start.
        run(1200);
        check_eq("release_cycle", rel_cycle0, 1026);
        check_eq("powerup_period", pm[0], REF);
        check_eq("powerup_freq_ok", fok[0], 1);

        // Off-frequency reference holds SETTLE, then a near-nominal one releases.
        tick_per = 125;
        run(1500);
        check_eq("offfreq_state", st[0], 1);
        check_eq("offfreq_sys_reset", sr[0], 1);
        tick_per = 121;
        run(500);
        check_eq("recover_state", st[0], 2);

        // Drop lock, then glitch it mid-settle; a full recount must follow.
        lock_x = 1'b0;
        run(10);
        lock_x = 1'b1;
        run(500);
        lock_x = 1'b0;
        run(5);
        lock_x = 1'b1;
        run(1020);
        check_eq("glitch_still_reset", sr[0], 1);
        run(20);
        check_eq("glitch_released", sr[0], 0);

        // Tolerance edges, then randomized lock drops and periods.
        tick_per = 123;
        run(400);
        tick_per = 122;
        run(1400);
        for (int it = 0; it < 15; it++) begin
            tick_per = $urandom_range(117, 124);
            if ($urandom_range(0, 3) == 0) begin
                lock_x = 1'b0;
                run($urandom_range(1, 20));
                lock_x = 1'b1;
            end
            run($urandom_range(100, 1500));
        end

        // Missing reference while running.
        tick_per = REF;
        lock_x   = 1'b1;
        run(1300);
        check_eq("pre_missing_state", st[0], 2);
        tick_en = 1'b0;
        for (int k = 0; k < 400 && fok[0] !== 1'b0; k++) step();
        check_eq("timeout_gap", p - m_last, TIMEOUT_C);
        step();
        check_eq("timeout_sys_reset", sr[0], 1);
        tick_en = 1'b1;

        // Repeated loss in RUN on the short-settle instance saturates its counter.
        for (int it = 0; it < 300; it++) begin
            lock_x = 1'b1;
            run(40);
            lock_x = 1'b0;
            run(4);
        end
        check_eq("lost_saturated", llc[1], 255);

        // Async reset mid-RUN; the first rise afterwards must not validate.
        lock_x = 1'b1;
        run(60);
        check_eq("pre_reset_state", st[1], 2);
        pulse_reset("midrun");
        nrise = 0;
        for (int k = 0; k < 400; k++) begin
            step();
            if (tick_rise_at(p - 1)) nrise++;
            if (nrise >= 2) break;
            check_eq($sformatf("no_fok_first_rise@%0d", p), fok[0], 0);
        end
        check_eq("two_rises_seen", nrise, 2);
        run(300);
        check_eq("post_reset_freq_ok", fok[0], 1);
        check_eq("post_reset_state", st[1], 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
